// File: rtl/amp_pkg.sv
// rtl/amp_pkg.sv - shared types and constants for the amplitude accumulator
package amp_pkg;

  localparam int COMPLEX_BIT = 24;
  localparam int GUARD_BIT   = 4;
  localparam int CNT_BIT     = 8;

  typedef logic signed [COMPLEX_BIT-1:0] amp_t;

  typedef struct packed {
    amp_t r;
    amp_t i;
  } complex_amp_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/amp_reduce.sv
// rtl/amp_reduce.sv - narrows one accumulator component, flags out-of-range values
// Optional macro AMP_SAT_EN: clamp out-of-range values instead of wrapping.
module amp_reduce #(
  parameter int IN_W  = 28,
  parameter int OUT_W = 24
) (
  input  logic signed [IN_W-1:0]  acc_in,
  output logic signed [OUT_W-1:0] val_out,
  output logic                    ovf_out
);

  logic [IN_W-OUT_W:0] upper;
  logic                fits;

  // The value fits when every bit above the output sign bit copies it.
  assign upper   = acc_in[IN_W-1:OUT_W-1];
  assign fits    = (&upper) | ~(|upper);
  assign ovf_out = ~fits;

`ifdef AMP_SAT_EN
  always_comb begin
    val_out = acc_in[OUT_W-1:0];
    if (!fits) begin
      val_out = acc_in[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                               : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end
`else
  assign val_out = acc_in[OUT_W-1:0];
`endif

endmodule

// File: rtl/amplitude_accumulator.sv
// rtl/amplitude_accumulator.sv - sums alpha-rotated complex terms per group, emits reduced result
// Optional macro AMP_SAT_EN selects saturation in amp_reduce instead of wrap.
module amplitude_accumulator
  import amp_pkg::*;
#(
  parameter int complex_bit = COMPLEX_BIT,
  parameter int guard_bit   = GUARD_BIT,
  parameter int cnt_bit     = CNT_BIT
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic                          in_last,
  input  logic signed [complex_bit-1:0] amplitude_in_r,
  input  logic signed [complex_bit-1:0] amplitude_in_i,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [complex_bit-1:0] amplitude_out_r,
  output logic signed [complex_bit-1:0] amplitude_out_i,
  output logic [cnt_bit-1:0]            term_count,
  output logic                          overflow
);

  localparam int AW = complex_bit + guard_bit;

  state_t                  state_q, state_d;
  logic signed [AW-1:0]    acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic [cnt_bit-1:0]      cnt_q, cnt_d, cnt_inc;
  logic signed [complex_bit-1:0] out_r_q, out_r_d, out_i_q, out_i_d;
  logic [cnt_bit-1:0]      tc_q, tc_d;
  logic                    ovf_q, ovf_d;

  logic signed [AW-1:0]    sum_r, sum_i;
  logic signed [complex_bit-1:0] red_r, red_i;
  logic                    ovf_r, ovf_i;

  assign sum_r   = acc_r_q + {{guard_bit{amplitude_in_r[complex_bit-1]}}, amplitude_in_r};
  assign sum_i   = acc_i_q + {{guard_bit{amplitude_in_i[complex_bit-1]}}, amplitude_in_i};
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + cnt_bit'(1);

  amp_reduce #(.IN_W(AW), .OUT_W(complex_bit)) u_reduce_r (
    .acc_in  (sum_r),
    .val_out (red_r),
    .ovf_out (ovf_r)
  );

  amp_reduce #(.IN_W(AW), .OUT_W(complex_bit)) u_reduce_i (
    .acc_in  (sum_i),
    .val_out (red_i),
    .ovf_out (ovf_i)
  );

  always_comb begin
    state_d = state_q;
    acc_r_d = acc_r_q;
    acc_i_d = acc_i_q;
    cnt_d   = cnt_q;
    out_r_d = out_r_q;
    out_i_d = out_i_q;
    tc_d    = tc_q;
    ovf_d   = ovf_q;
    case (state_q)
      ACCUM: begin
        if (in_valid) begin
          if (in_last) begin
            // Result is taken from acc + current term; accumulator restarts empty.
            out_r_d = red_r;
            out_i_d = red_i;
            tc_d    = cnt_inc;
            ovf_d   = ovf_r | ovf_i;
            acc_r_d = '0;
            acc_i_d = '0;
            cnt_d   = '0;
            state_d = HOLD;
          end else begin
            acc_r_d = sum_r;
            acc_i_d = sum_i;
            cnt_d   = cnt_inc;
          end
        end
      end
      HOLD: begin
        if (out_ready) state_d = ACCUM;
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_r_q <= '0;
      acc_i_q <= '0;
      cnt_q   <= '0;
      out_r_q <= '0;
      out_i_q <= '0;
      tc_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_r_q <= acc_r_d;
      acc_i_q <= acc_i_d;
      cnt_q   <= cnt_d;
      out_r_q <= out_r_d;
      out_i_q <= out_i_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready        = (state_q == ACCUM);
  assign out_valid       = (state_q == HOLD);
  assign amplitude_out_r = out_r_q;
  assign amplitude_out_i = out_i_q;
  assign term_count      = tc_q;
  assign overflow        = ovf_q;

endmodule

// File: tb/tb_amplitude_accumulator.sv
// tb/tb_amplitude_accumulator.sv - directed self-checking bench for amplitude_accumulator
module tb_amplitude_accumulator;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic               in_last;
  logic signed [23:0] amplitude_in_r;
  logic signed [23:0] amplitude_in_i;
  logic               out_valid;
  logic               out_ready;
  logic signed [23:0] amplitude_out_r;
  logic signed [23:0] amplitude_out_i;
  logic [7:0]         term_count;
  logic               overflow;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  amplitude_accumulator dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_last         (in_last),
    .amplitude_in_r  (amplitude_in_r),
    .amplitude_in_i  (amplitude_in_i),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .amplitude_out_r (amplitude_out_r),
    .amplitude_out_i (amplitude_out_i),
    .term_count      (term_count),
    .overflow        (overflow)
  );

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic send(input int r, input int i, input bit last);
    int n;
    amplitude_in_r = 24'(r);
    amplitude_in_i = 24'(i);
    in_last        = last;
    in_valid       = 1'b1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow, in_ready} !==
        {1'b0, 24'sd0, 24'sd0, 8'd0, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: v=%0b r=%0d i=%0d cnt=%0d ovf=%0b rdy=%0b required 0 0 0 0 0 1",
               out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow, in_ready);
    end
  endtask

  task automatic test_three_terms;
    send(100, -5, 0);
    send(-30, 20, 0);
    send(7, 7, 1);
    checks++;
    if ({out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow} !==
        {1'b1, 24'sd77, 24'sd22, 8'd3, 1'b0}) begin
      errors++;
      $display("FAIL three_terms: v=%0b r=%0d i=%0d cnt=%0d ovf=%0b required 1 77 22 3 0",
               out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow);
    end
    pop();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL three_terms_release: v=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_hold_stall;
    send(-1, 1, 1);
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({out_valid, in_ready, amplitude_out_r, amplitude_out_i, term_count} !==
          {1'b1, 1'b0, -24'sd1, 24'sd1, 8'd1}) begin
        errors++;
        $display("FAIL hold_stall[%0d]: v=%0b rdy=%0b r=%0d i=%0d cnt=%0d required 1 0 -1 1 1",
                 k, out_valid, in_ready, amplitude_out_r, amplitude_out_i, term_count);
      end
      @(negedge clk);
    end
    pop();
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL hold_release: v=%0b rdy=%0b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_overflow;
    logic signed [23:0] exp_r, exp_i;
`ifdef AMP_SAT_EN
    exp_r = 24'sh7FFFFF;
    exp_i = 24'sh800000;
`else
    exp_r = -24'sd4;
    exp_i = 24'sd0;
`endif
    for (int k = 0; k < 4; k++) send(8388607, -8388608, k == 3);
    checks++;
    if ({out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow} !==
        {1'b1, exp_r, exp_i, 8'd4, 1'b1}) begin
      errors++;
      $display("FAIL overflow: v=%0b r=%0d i=%0d cnt=%0d ovf=%0b required 1 %0d %0d 4 1",
               out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow, exp_r, exp_i);
    end
    pop();
  endtask

  task automatic test_cancel;
    send(5, 5, 0);
    send(-5, -5, 1);
    checks++;
    if ({out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow} !==
        {1'b1, 24'sd0, 24'sd0, 8'd2, 1'b0}) begin
      errors++;
      $display("FAIL cancel: v=%0b r=%0d i=%0d cnt=%0d ovf=%0b required 1 0 0 2 0",
               out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow);
    end
    pop();
  endtask

  task automatic test_reset_mid_group;
    send(1000, -1000, 0);
    send(22, 33, 0);
    test_reset();
    send(3, 4, 1);
    checks++;
    if ({out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow} !==
        {1'b1, 24'sd3, 24'sd4, 8'd1, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid_group: v=%0b r=%0d i=%0d cnt=%0d ovf=%0b required 1 3 4 1 0",
               out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow);
    end
    pop();
  endtask

  task automatic test_count_saturate;
    for (int k = 0; k < 300; k++) send(1, 0, k == 299);
    checks++;
    if ({out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow} !==
        {1'b1, 24'sd300, 24'sd0, 8'd255, 1'b0}) begin
      errors++;
      $display("FAIL count_saturate: v=%0b r=%0d i=%0d cnt=%0d ovf=%0b required 1 300 0 255 0",
               out_valid, amplitude_out_r, amplitude_out_i, term_count, overflow);
    end
    pop();
  endtask

  task automatic test_reset_in_hold;
    send(9, 9, 1);
    test_reset();
  endtask

  initial begin
    rst            = 1'b1;
    in_valid       = 1'b0;
    in_last        = 1'b0;
    amplitude_in_r = '0;
    amplitude_in_i = '0;
    out_ready      = 1'b0;
    @(negedge clk);
    test_reset();
    test_three_terms();
    test_hold_stall();
    test_overflow();
    test_cancel();
    test_reset_mid_group();
    test_count_saturate();
    test_reset_in_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/amplitude_accumulator.md
Name: amplitude_accumulator

Overview:
- Downstream of the alpha-multiply stage. Accepts a stream of complex amplitudes already rotated by alpha (+1/-1/+i/-i).
- Sums all terms belonging to one basis state (a group ends on in_last) into a wide accumulator.
- Presents the reduced complex amplitude on a valid/ready output for the next emulation stage.

Parameters:
- complex_bit, 24, width of each real/imag component, signed two's complement, on input and output.
- guard_bit, 4, extra accumulator MSBs; the accumulator is complex_bit+guard_bit wide.
- cnt_bit, 8, width of the term counter.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  input term valid.
- in_ready  out  1  block can accept a term.
- in_last  in  1  term is the final one of the current group.
- amplitude_in_r  in  complex_bit  signed real part of the term.
- amplitude_in_i  in  complex_bit  signed imaginary part of the term.
- out_valid  out  1  reduced amplitude valid.
- out_ready  in  1  consumer accepts the result.
- amplitude_out_r  out  complex_bit  signed real sum.
- amplitude_out_i  out  complex_bit  signed imaginary sum.
- term_count  out  cnt_bit  number of terms in the emitted group.
- overflow  out  1  group sum exceeded the complex_bit range in either component.

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to ACCUM.
  - Accumulators, counter and outputs all become 0: out_valid=0, amplitude_out_*=0, term_count=0, overflow=0.
  - in_ready=1 from the first cycle after reset.
  - Reset mid-group discards any partial sum. Reset while in HOLD drops the pending result without a handshake.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - A term is accepted when in_valid & in_ready.
  - On accept: acc_r += sign-extended amplitude_in_r, acc_i += sign-extended amplitude_in_i, count += 1. The count saturates at 2^cnt_bit-1 and does not wrap.
  - Accept with in_last=1:
    - Compute final = acc + current term.
    - Register the outputs from final and move to HOLD.
    - out_valid=1 in the next cycle, so result latency is 1 clock after the last-beat handshake.
    - Clear the accumulators and counter in the same edge.
  - A group of one term (in_last on the first beat) is legal. Its output equals that term, term_count=1.
- State HOLD:
  - in_ready=0, out_valid=1. Outputs stay stable until out_ready=1.
  - On out_valid & out_ready: out_valid=0, return to ACCUM, in_ready=1 in the next cycle.
  - No input/output overlap: one bubble cycle between groups.
- Width rules:
  - Each component is reduced from complex_bit+guard_bit bits to complex_bit bits.
  - If the value fits, it passes unchanged.
  - Otherwise overflow=1 and the component is handled per AMP_SAT_EN.
  - overflow is registered with the outputs and held through HOLD.
- Simultaneous in_valid while in HOLD: not accepted (in_ready=0); the upstream stage must hold its term.
- Terms that cancel to exactly 0 produce output 0 with overflow=0.

Optional Feature:
- Macro AMP_SAT_EN.
- Defined: an out-of-range component clamps to +(2^(complex_bit-1)-1) or -2^(complex_bit-1) according to the accumulator sign.
- Undefined: the component is truncated to its low complex_bit bits (wrap).
- overflow reports the condition in both builds.

Decomposition:
- Shared package amp_pkg:
  - COMPLEX_BIT constant.
  - typedef amp_t (signed [COMPLEX_BIT-1:0]).
  - typedef complex_amp_t struct {r, i}.
  - State enum {ACCUM, HOLD}.
- One sub-module: amp_reduce, a combinational narrowing/saturation unit, instantiated once per component. It contains the AMP_SAT_EN logic and drives a per-component overflow bit; the two bits are ORed.

Test Plan:
- Three terms (100,-5),(-30,20),(7,7), last on the third -> one cycle later out (77,22), term_count=3, overflow=0.
- Single term (-1,1) with in_last; hold out_ready=0 for 4 cycles -> outputs stable, in_ready=0 throughout; after out_ready=1, in_ready=1 the next cycle.
- complex_bit=24, four terms of (8388607,-8388608) -> overflow=1. With AMP_SAT_EN: out (8388607,-8388608). Without: low 24 bits of (33554428,-33554432), i.e. (-4,0).
- Terms (5,5),(-5,-5) -> out (0,0), overflow=0, term_count=2.
- Assert rst after two accepted terms of a group, then send (3,4) with last -> out (3,4), term_count=1, with no residue from the aborted group.
- 300 terms of (1,0) with cnt_bit=8 -> out (300,0) (fits with guard bits), term_count=255 (saturated).
